// File: rtl/jcr_mem_arbiter.sv
// -----------------------------------------------------------------------------
// jcr_mem_arbiter
//
// Shares the single-port program/data SRAM of the `computer` core between the
// jacaranda-8 CPU memory port and the Caravel Wishbone slave. The management
// SoC uses the Wishbone side to load programs and inspect memory. Also holds
// the CTRL.run bit that keeps the CPU in reset while a program loads.
//
// Ports:
//   wb_clk_i, wb_rst_i   sole clock, asynchronous active-high reset
//   wbs_*                Wishbone slave (single-cycle ack, 32-bit data)
//                        window BASE_ADDR .. BASE_ADDR+0x7FF:
//                          0x000..0x3FF  SRAM words, data on byte lane 0
//                          0x400         CTRL, bit0 = run
//                          others        read 0, writes ignored, acked
//   cpu_*                CPU memory port; cpu_gnt is combinational,
//                        cpu_rvalid/cpu_rdata follow one cycle later
//   cpu_rst_o            CPU reset, high while run = 0
//   mem_*                SRAM macro port; mem_rdata valid the cycle after
//                        a read enable
// -----------------------------------------------------------------------------
module jcr_mem_arbiter #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // Wishbone slave
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  // CPU memory port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rst_o,
  // SRAM macro
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Wishbone FSM encoding
  localparam logic [1:0] WB_IDLE = 2'd0;
  localparam logic [1:0] WB_RD   = 2'd1;
  localparam logic [1:0] WB_ACK  = 2'd2;

  // last_grant encoding
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_WB  = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        run_q, run_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] wbs_dat_q, wbs_dat_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic hit, sram_sel, ctrl_sel;

  assign hit      = wbs_cyc_i && wbs_stb_i &&
                    (wbs_adr_i[31:11] == BASE_ADDR[31:11]);
  assign sram_sel = !wbs_adr_i[10];
  assign ctrl_sel = (wbs_adr_i[10:2] == 9'h100);

  // ---------------------------------------------------------------------------
  // Arbitration: one SRAM access per cycle, round-robin on contention
  // ---------------------------------------------------------------------------
  logic wb_pend, cpu_pend, grant_wb, grant_cpu;

  // Gated by reset so the SRAM stays idle while reset is held, even if the
  // master keeps its strobe up.
  assign wb_pend  = !wb_rst_i && (state_q == WB_IDLE) && hit && sram_sel;
  // A halted CPU is invisible to the arbiter.
  assign cpu_pend = cpu_req && run_q;

  assign grant_wb  = wb_pend && (!cpu_pend || (last_grant_q == GNT_CPU));
  assign grant_cpu = cpu_pend && !grant_wb;

  assign mem_en    = grant_wb || grant_cpu;
  // A Wishbone write without lane 0 still takes its slot but writes nothing.
  assign mem_we    = grant_wb ? (wbs_we_i && wbs_sel_i[0]) : (grant_cpu && cpu_we);
  assign mem_addr  = grant_wb ? wbs_adr_i[ADDR_W+1:2] : cpu_addr;
  assign mem_wdata = grant_wb ? wbs_dat_i[DATA_W-1:0] : cpu_wdata;

  assign cpu_gnt      = grant_cpu;
  assign cpu_rvalid_d = grant_cpu && !cpu_we;

  // The SRAM output register already holds the data in the cycle after the
  // read; it is passed through and forced to zero when not valid.
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;

  assign cpu_rst_o = !run_q;
  assign wbs_ack_o = (state_q == WB_ACK);
  assign wbs_dat_o = wbs_dat_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    run_d        = run_q;
    wbs_dat_d    = wbs_dat_q;
    last_grant_d = last_grant_q;

    if (grant_wb)       last_grant_d = GNT_WB;
    else if (grant_cpu) last_grant_d = GNT_CPU;

    case (state_q)
      WB_IDLE: begin
        if (hit) begin
          if (sram_sel) begin
            // Wait in IDLE until the arbiter hands the SRAM to Wishbone.
            if (grant_wb) state_d = wbs_we_i ? WB_ACK : WB_RD;
          end else begin
            state_d = WB_ACK;
            if (ctrl_sel) begin
              if (wbs_we_i && wbs_sel_i[0]) run_d = wbs_dat_i[0];
              if (!wbs_we_i)                wbs_dat_d = {31'b0, run_q};
            end else if (!wbs_we_i) begin
              wbs_dat_d = '0;
            end
          end
        end
      end
      WB_RD: begin
        // Completes even if cyc has been dropped; the stray ack is harmless.
        wbs_dat_d               = '0;
        wbs_dat_d[DATA_W-1:0]   = mem_rdata;
        state_d                 = WB_ACK;
      end
      WB_ACK:  state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= WB_IDLE;
      run_q        <= 1'b0;
      last_grant_q <= GNT_CPU;
      wbs_dat_q    <= '0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      last_grant_q <= last_grant_d;
      wbs_dat_q    <= wbs_dat_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  // Address bits [1:0], upper data bits and lanes 1..3 carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

endmodule

// File: tb/tb_jcr_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_jcr_mem_arbiter
//
// Directed sequence with randomized data and CPU addresses. A simple array
// (exp_mem) holds the expected SRAM contents, updated from the Wishbone write
// rules; CPU grant counts are derived from the round-robin and run rules.
// A behavioural SRAM (read-first, registered output) sits on the mem_* port.
// -----------------------------------------------------------------------------
module tb_jcr_mem_arbiter;

  localparam int          ADDR_W     = 8;
  localparam int          DATA_W     = 8;
  localparam logic [31:0] BASE       = 32'h3000_0000;
  localparam int          WB_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid, cpu_rst_o;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_mem [2**ADDR_W];
  logic [DATA_W-1:0] sram    [2**ADDR_W];

  always #5 clk = ~clk;

  jcr_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_rst_o  (cpu_rst_o),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Behavioural SRAM macro: registered read data, held when idle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone transaction; lat counts cycles from strobe to ack inclusive.
  task automatic wb_access(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           output logic [31:0] rdata, output int lat,
                           output logic first_en, output logic [ADDR_W-1:0] first_addr);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    rdata = '0; lat = 0; first_en = 1'b0; first_addr = '0;
    for (int k = 0; k < WB_TIMEOUT; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        first_en   = mem_en;
        first_addr = mem_addr;
      end
      if (wbs_ack_o) begin
        rdata = wbs_dat_o;
        break;
      end
      if (k == WB_TIMEOUT - 1) check("wb_ack_within_budget", 32'(wbs_ack_o), 32'd1);
      tick();
    end
    tick();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
    check("wb_ack_single_cycle", 32'(wbs_ack_o), 32'd0);
    tick();
  endtask

  // Model-side update of the SRAM image for a Wishbone write.
  task automatic wb_write_model(input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel);
    if (adr[31:11] == BASE[31:11] && !adr[10] && sel[0])
      exp_mem[adr[ADDR_W+1:2]] = dat[DATA_W-1:0];
  endtask

  // CPU read stream for n cycles; checks rvalid/rdata against the image.
  task automatic cpu_stream(input int n, input bit seq,
                            output int grants, output int misses, output int gnt_halted);
    logic              prev_rd;
    logic [DATA_W-1:0] prev_exp;
    prev_rd = 1'b0; prev_exp = '0;
    grants = 0; misses = 0; gnt_halted = 0;
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) begin
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = seq ? ADDR_W'(c) : ADDR_W'($urandom_range(0, 15));
      end else begin
        cpu_req = 1'b0;
      end
      @(negedge clk);
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(prev_rd));
      if (prev_rd) check("cpu_rdata", 32'(cpu_rdata), 32'(prev_exp));
      prev_rd = cpu_req && cpu_gnt;
      if (prev_rd) begin
        grants++;
        if (cpu_rst_o) gnt_halted++;
        prev_exp = exp_mem[cpu_addr];
      end else if (cpu_req) begin
        misses++;
      end
      tick();
    end
  endtask

  initial begin
    logic [31:0]       rd;
    int                lat, g, m, h, acks, ens;
    logic              fe;
    logic [ADDR_W-1:0] fa;
    logic [31:0]       adr;

    rst = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0;   wbs_dat_i = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    foreach (exp_mem[i]) exp_mem[i] = '0;

    // 1. Reset values
    repeat (3) tick();
    @(negedge clk);
    check("rst_wbs_ack",    32'(wbs_ack_o),  32'd0);
    check("rst_wbs_dat",    wbs_dat_o,       32'd0);
    check("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
    check("rst_mem_en",     32'(mem_en),     32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_cpu_rst",    32'(cpu_rst_o),  32'd1);
    tick();
    rst = 1'b0;
    tick();

    wb_access(1'b0, BASE + 32'h400, '0, 4'hF, rd, lat, fe, fa);
    check("ctrl_rd_data", rd, 32'd0);
    check("ctrl_rd_lat",  32'(lat), 32'd2);

    // 2. SRAM write/read through Wishbone, lane-0 rule
    wb_access(1'b1, BASE + 32'h10, 32'hA5, 4'hF, rd, lat, fe, fa);
    wb_write_model(BASE + 32'h10, 32'hA5, 4'hF);
    check("sram_wr_lat", 32'(lat), 32'd2);
    wb_access(1'b0, BASE + 32'h10, '0, 4'hF, rd, lat, fe, fa);
    check("sram_rd_mem_en",   32'(fe), 32'd1);
    check("sram_rd_mem_addr", 32'(fa), 32'd4);
    check("sram_rd_data",     rd, 32'(exp_mem[4]));
    check("sram_rd_lat",      32'(lat), 32'd3);
    wb_access(1'b1, BASE + 32'h10, 32'hFFFF_FF3C, 4'b1110, rd, lat, fe, fa);
    wb_write_model(BASE + 32'h10, 32'hFFFF_FF3C, 4'b1110);
    wb_access(1'b0, BASE + 32'h10, '0, 4'hF, rd, lat, fe, fa);
    check("sram_sel0_clear_keeps", rd, 32'(exp_mem[4]));

    // Unmapped offset inside the window: acked, reads zero
    wb_access(1'b1, BASE + 32'h500, 32'hFF, 4'hF, rd, lat, fe, fa);
    check("unmapped_wr_lat", 32'(lat), 32'd2);
    wb_access(1'b0, BASE + 32'h500, '0, 4'hF, rd, lat, fe, fa);
    check("unmapped_rd_data", rd, 32'd0);

    // CTRL write without lane 0 leaves run alone
    wb_access(1'b1, BASE + 32'h400, 32'h1, 4'b1110, rd, lat, fe, fa);
    check("ctrl_sel0_clear_run", 32'(cpu_rst_o), 32'd1);

    // Preload words 0..15 with random data
    for (int i = 0; i < 16; i++) begin
      adr = BASE + 32'(i * 4);
      wb_access(1'b1, adr, $urandom, 4'hF, rd, lat, fe, fa);
      wb_write_model(adr, wbs_dat_i, 4'hF);
    end
    wb_access(1'b0, BASE + 32'h1C, '0, 4'hF, rd, lat, fe, fa);
    check("preload_rd_word7", rd, 32'(exp_mem[7]));

    // 3. Release the CPU and stream reads 0..15
    wb_access(1'b1, BASE + 32'h400, 32'h1, 4'h1, rd, lat, fe, fa);
    check("run_set_cpu_rst", 32'(cpu_rst_o), 32'd0);
    wb_access(1'b0, BASE + 32'h400, '0, 4'hF, rd, lat, fe, fa);
    check("ctrl_rd_run", rd, 32'd1);
    cpu_stream(16, 1'b1, g, m, h);
    check("seq_grants", 32'(g), 32'd16);
    check("seq_misses", 32'(m), 32'd0);

    // 4. CPU saturating plus a simultaneous Wishbone read
    fork
      cpu_stream(20, 1'b0, g, m, h);
      wb_access(1'b0, BASE + 32'h20, '0, 4'hF, rd, lat, fe, fa);
    join
    check("contend_cpu_misses", 32'(m), 32'd1);
    check("contend_cpu_grants", 32'(g), 32'd19);
    check("contend_wb_lat_bound", 32'(lat <= 4), 32'd1);
    check("contend_wb_data", rd, 32'(exp_mem[8]));

    // 5. Halt the CPU mid-stream: CTRL write issued in stream cycle 4
    fork
      cpu_stream(12, 1'b0, g, m, h);
      begin
        repeat (4) tick();
        wb_access(1'b1, BASE + 32'h400, 32'h0, 4'h1, rd, lat, fe, fa);
        check("halt_cpu_rst_at_ack", 32'(cpu_rst_o), 32'd1);
      end
    join
    check("halt_grants", 32'(g), 32'd5);
    check("halt_gnt_while_halted", 32'(h), 32'd0);

    // 6a. Strobe just past the window: never acked, never touches SRAM
    wb_access(1'b1, BASE + 32'h400, 32'h1, 4'h1, rd, lat, fe, fa);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE + 32'h800; wbs_sel_i = 4'hF;
    acks = 0; ens = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
      if (mem_en)    ens++;
      tick();
    end
    check("miss_no_ack",    32'(acks), 32'd0);
    check("miss_no_mem_en", 32'(ens),  32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();

    // 6b. Reset asserted during WB_RD
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE + 32'h4;
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_ack",     32'(wbs_ack_o),  32'd0);
    check("midrst_dat",     wbs_dat_o,       32'd0);
    check("midrst_mem_en",  32'(mem_en),     32'd0);
    check("midrst_rvalid",  32'(cpu_rvalid), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst_o),  32'd1);
    tick();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
      tick();
    end
    check("midrst_no_late_ack", 32'(acks), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jcr_mem_arbiter.md
Name: jcr_mem_arbiter

Overview:
- Shares the single-port program/data SRAM of the `computer` core between two requesters: the jacaranda-8 CPU memory port and the Caravel Wishbone slave bus.
- The management SoC uses the Wishbone side to load programs and inspect memory.
- Also holds the control register that keeps the CPU in reset while a program loads.
- Sits inside `computer`, between the Wishbone pins, the CPU core and the SRAM macro.

Parameters:
- ADDR_W, 8: SRAM word address width; depth is 2^ADDR_W.
- DATA_W, 8: SRAM / CPU data width. DATA_W <= 32.
- BASE_ADDR, 32'h3000_0000: Wishbone window base. Window size is 0x800 bytes.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; lane 0 must be set for SRAM writes to take effect.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, zero-extended.
- cpu_req  in  1  CPU memory request.
- cpu_we  in  1  CPU write.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_rvalid  out  1  read data valid.
- cpu_rdata  out  DATA_W  read data.
- cpu_rst_o  out  1  CPU reset; high while halted.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data; valid the cycle after a read enable.

Behaviour:
- Reset (async, wb_rst_i=1):
  - wbs_ack_o=0, wbs_dat_o=0, cpu_gnt=0, cpu_rvalid=0, cpu_rdata=0.
  - mem_en=0, mem_we=0.
  - run=0, so cpu_rst_o=1.
  - last_grant=CPU, Wishbone FSM=WB_IDLE.
- Address decode: hit = cyc & stb & (adr[31:11] == BASE_ADDR[31:11]).
  - Offset 0x000..0x3FF: SRAM word adr[ADDR_W+1:2], data on byte lane 0; bytes 1..3 read 0, writes ignored. Words at or beyond 2^ADDR_W alias modulo depth.
  - Offset 0x400: CTRL. Bit0 = run; reads return {31'b0, run}. Write updates run only if sel[0].
  - Other offsets in the window: writes ignored, read 0, still acked.
  - Misses are never acked.
- Wishbone FSM states: WB_IDLE, WB_RD, WB_ACK.
  - WB_IDLE, hit to CTRL/unmapped → WB_ACK; register updated in that edge.
  - WB_IDLE, hit to SRAM, and granted this cycle → write: WB_ACK; read: WB_RD.
  - WB_RD → WB_ACK; wbs_dat_o <= {0, mem_rdata}.
  - WB_ACK: wbs_ack_o=1 for exactly one cycle → WB_IDLE. A new hit is not accepted in this cycle.
  - Latency (hit to ack): SRAM write/CTRL = 2 cycles minimum; SRAM read = 3 cycles minimum.
- Arbitration: combinational, one SRAM access per cycle. Candidates are cpu_req, and wb_pend (WB_IDLE & SRAM hit).
  - Only one pending → it wins.
  - Both pending → the one ≠ last_grant wins (round-robin). last_grant updates on every grant.
  - While run=0, cpu_req is ignored (cpu_gnt=0).
- SRAM drive: the winner's en/we/addr/wdata go to mem_*.
  - cpu_gnt is combinational, same cycle as mem_en.
  - cpu_rvalid=1 the next cycle for granted reads, with cpu_rdata = mem_rdata registered through.
  - CPU may issue back-to-back every granted cycle.
  - Wishbone occupies the SRAM only in its grant cycle, so the CPU may use the SRAM during WB_RD/WB_ACK.
- Writing run 1→0: cpu_rst_o rises the next cycle.
  - A CPU access granted in the same cycle still completes; its cpu_rvalid is still produced.
- cyc dropped mid-transaction (in WB_RD): the FSM still completes through WB_ACK. Ack while cyc=0 is harmless.
- Starvation bound: with both requesters saturating, each gets at least one grant in every 2 cycles.

Test Plan:
1. Reset → cpu_rst_o=1, all acks/valids 0. WB read at 0x3000_0400 → wbs_dat_o=0 with ack 2 cycles after stb.
2. WB write 0xA5 to 0x3000_0010, then read 0x3000_0010 → mem_addr=4; read returns 0x0000_00A5 with ack on cycle 3. Write with sel=4'b1110 → SRAM unchanged.
3. Write CTRL=1 → cpu_rst_o=0. CPU reads 0..15 back-to-back → cpu_gnt every cycle; cpu_rvalid one cycle later with the preloaded data.
4. CPU saturating plus a WB read at the same cycle → WB granted within 2 cycles. CPU grant pattern shows exactly one missing cycle. CPU data still correct.
5. Write CTRL=0 while CPU is reading → last granted read still returns cpu_rvalid; no further cpu_gnt.
6. Stb to 0x3000_0800 → no ack for 20 cycles. Assert wb_rst_i mid WB_RD → ack never appears and outputs are immediately at reset values.
